// File: rtl/muldiv_arbiter.sv
// Round-robin arbiter sharing one iterative muldiv unit among NREQ requesters.
// Short-circuits RISC-V divide-by-zero and signed overflow without starting the divider.
module muldiv_arbiter #(
    parameter int XLEN = 32,
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [3*NREQ-1:0]    req_op,
    input  logic [XLEN*NREQ-1:0] req_a,
    input  logic [XLEN*NREQ-1:0] req_b,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [XLEN-1:0]      resp_result,
    output logic                 md_start,
    output logic [2:0]           md_op,
    output logic [XLEN-1:0]      md_a,
    output logic [XLEN-1:0]      md_b,
    input  logic [XLEN-1:0]      md_result,
    input  logic                 md_busy,
    input  logic                 md_valid
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   gnt;
    logic            any_req;
    int              idx;
    logic [2:0]      sel_op;
    logic [XLEN-1:0] sel_a;
    logic [XLEN-1:0] sel_b;
    logic            fast;
    logic [XLEN-1:0] fast_res;
    logic [XLEN-1:0] result;
    logic            capture;
    logic            hs;

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        any_req = 1'b0;
        gnt     = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!any_req && req_valid[idx]) begin
                any_req = 1'b1;
                gnt     = idx[IW-1:0];
            end
        end
    end

    assign sel_op = req_op[3*int'(gnt) +: 3];
    assign sel_a  = req_a[XLEN*int'(gnt) +: XLEN];
    assign sel_b  = req_b[XLEN*int'(gnt) +: XLEN];

    // op[2]=divide class, op[1]=remainder, op[0]=unsigned.
    always_comb begin
        fast     = 1'b0;
        fast_res = '0;
        if (sel_op[2]) begin
            if (sel_b == '0) begin
                fast     = 1'b1;
                fast_res = sel_op[1] ? sel_a : '1;
            end else if (!sel_op[0] && sel_b == '1 &&
                         sel_a == {1'b1, {(XLEN-1){1'b0}}}) begin
                fast     = 1'b1;
                fast_res = sel_op[1] ? '0 : sel_a;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        req_ready  = '0;
        resp_valid = '0;
        md_start   = 1'b0;
        capture    = 1'b0;
        hs         = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    req_ready[gnt] = 1'b1;
                    state_nx       = fast ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (!md_busy) begin
                    md_start = 1'b1;
                    if (!md_op[2] && md_valid) begin
                        capture  = 1'b1;
                        state_nx = RESP;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (md_valid) begin
                    capture  = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                resp_valid[owner] = 1'b1;
                if (resp_ready[owner]) begin
                    hs       = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign resp_result = result;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            md_op  <= '0;
            md_a   <= '0;
            md_b   <= '0;
            result <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                owner <= gnt;
                md_op <= sel_op;
                md_a  <= sel_a;
                md_b  <= sel_b;
                if (fast) begin
                    result <= fast_res;
                end
            end
            if (capture) begin
                result <= md_result;
            end
            if (hs) begin
                rr_ptr <= (owner == IW'(NREQ-1)) ? '0 : owner + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed bench for muldiv_arbiter with a behavioural muldiv unit model.
// Mul results arrive with md_start; divides 32 cycles later plus one busy drain.
module tb_muldiv_arbiter;

    localparam int XLEN = 32;
    localparam int NREQ = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [3*NREQ-1:0]    req_op;
    logic [XLEN*NREQ-1:0] req_a;
    logic [XLEN*NREQ-1:0] req_b;
    logic [NREQ-1:0]      resp_valid;
    logic [NREQ-1:0]      resp_ready;
    logic [XLEN-1:0]      resp_result;
    logic                 md_start;
    logic [2:0]           md_op;
    logic [XLEN-1:0]      md_a;
    logic [XLEN-1:0]      md_b;
    logic [XLEN-1:0]      md_result;
    logic                 md_busy;
    logic                 md_valid;

    int total = 0;
    int bad   = 0;
    int starts = 0;

    always #5 clk = ~clk;

    muldiv_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result),
        .md_start(md_start), .md_op(md_op), .md_a(md_a), .md_b(md_b),
        .md_result(md_result), .md_busy(md_busy), .md_valid(md_valid)
    );

    function automatic logic [31:0] mul_fn(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        logic signed [63:0] sa, sb, ub;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        case (op[1:0])
            2'd0: p = {32'b0, a * b};
            2'd1: p = sa * sb;
            2'd2: p = sa * ub;
            default: p = {32'b0, a} * {32'b0, b};
        endcase
        return (op[1:0] == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] div_fn(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        case (op[1:0])
            2'd0: return $signed(a) / $signed(b);
            2'd1: return a / b;
            2'd2: return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    // Behavioural muldiv unit
    logic        div_act;
    logic        drain;
    logic [5:0]  div_cnt;
    logic [31:0] div_q;

    assign md_busy   = div_act | drain;
    assign md_valid  = (md_start && !md_op[2]) || (div_act && div_cnt == 6'd32);
    assign md_result = md_op[2] ? div_q : mul_fn(md_op, md_a, md_b);

    always @(posedge clk) begin
        if (rst) begin
            div_act <= 1'b0;
            drain   <= 1'b0;
            div_cnt <= '0;
            div_q   <= '0;
        end else begin
            drain <= 1'b0;
            if (md_start && md_op[2]) begin
                div_act <= 1'b1;
                div_cnt <= 6'd1;
                div_q   <= div_fn(md_op, md_a, md_b);
            end else if (div_act) begin
                if (div_cnt == 6'd32) begin
                    div_act <= 1'b0;
                    drain   <= 1'b1;
                end
                div_cnt <= div_cnt + 6'd1;
            end
        end
    end

    always @(posedge clk) if (md_start) starts <= starts + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, " resp_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, " resp_result"}, 64'(resp_result), 64'd0);
        chk({tag, " md_start"}, 64'(md_start), 64'd0);
        chk({tag, " md_op/a/b"}, 64'({md_op, md_a | md_b}), 64'd0);
    endtask

    task automatic set_req(input int i, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        req_op[3*i +: 3] = op;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic do_txn(input string name, input int i, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input int lat_exp, input int st_exp);
        int s0;
        int lat;
        @(posedge clk);
        #1;
        set_req(i, op, a, b);
        req_valid[i] = 1'b1;
        s0 = starts;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (req_ready != 0) break;
        end
        chk({name, " req_ready"}, 64'(req_ready), 64'(1 << i));
        @(posedge clk);
        #1;
        req_valid = '0;
        lat = 1;
        while (resp_valid == 0 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, " latency"}, 64'(lat), 64'(lat_exp));
        chk({name, " resp_valid"}, 64'(resp_valid), 64'(1 << i));
        chk({name, " result"}, 64'(resp_result), 64'(res));
        chk({name, " md_start count"}, 64'(starts - s0), 64'(st_exp));
        resp_ready[i] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = '0;
        chk({name, " resp drop"}, 64'(resp_valid), 64'd0);
    endtask

    typedef struct {
        string       name;
        int          idx;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        int          st;
    } vec_t;

    vec_t v[12];

    initial begin
        v[0]  = '{"mul7x6",     0, 3'd0, 32'd7,         32'd6,         32'd42,        2,  1};
        v[1]  = '{"divu100/7",  1, 3'd5, 32'd100,       32'd7,         32'd14,        34, 1};
        v[2]  = '{"remu100/7",  1, 3'd7, 32'd100,       32'd7,         32'd2,         34, 1};
        v[3]  = '{"div5/0",     0, 3'd4, 32'd5,         32'd0,         32'hFFFFFFFF,  1,  0};
        v[4]  = '{"rem5/0",     0, 3'd6, 32'd5,         32'd0,         32'd5,         1,  0};
        v[5]  = '{"div_ovf",    0, 3'd4, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1,  0};
        v[6]  = '{"rem_ovf",    0, 3'd6, 32'h80000000,  32'hFFFFFFFF,  32'd0,         1,  0};
        v[7]  = '{"mulh-1x2",   1, 3'd1, 32'hFFFFFFFF,  32'd2,         32'hFFFFFFFF,  2,  1};
        v[8]  = '{"div-7/2",    0, 3'd4, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  34, 1};
        v[9]  = '{"rem-7/2",    1, 3'd6, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  34, 1};
        v[10] = '{"divu_big",   0, 3'd5, 32'h80000000,  32'hFFFFFFFF,  32'd0,         34, 1};
        v[11] = '{"remu9/0",    1, 3'd7, 32'd9,         32'd0,         32'd9,         1,  0};

        rst = 1'b1;
        req_valid = '0;
        resp_ready = '0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int n = 0; n < 12; n++) begin
            do_txn(v[n].name, v[n].idx, v[n].op, v[n].a, v[n].b, v[n].res, v[n].lat, v[n].st);
        end

        // Alternating grants with both requesters held valid
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_req(0, 3'd3, 32'hFFFFFFFF, 32'd2);
        set_req(1, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        resp_ready = 2'b11;
        req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (req_ready != 0) break;
            end
            chk("rr grant", 64'(req_ready), 64'(1 << (g % 2)));
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (resp_valid != 0) break;
            end
            chk("rr owner", 64'(resp_valid), 64'(1 << (g % 2)));
            chk("rr result", 64'(resp_result), (g % 2) ? 64'hFFFFFFFE : 64'h1);
            if (g == 3) req_valid = '0;
        end
        @(posedge clk);
        #1;
        resp_ready = '0;

        // Response held under backpressure
        set_req(0, 3'd0, 32'd3, 32'd5);
        req_valid[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready != 0) break;
        end
        chk("hold grant", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("hold state", 64'({resp_valid, req_ready, resp_result}), {32'h0, 2'b01, 2'b00, 32'd15});
        end
        req_valid = '0;
        resp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = '0;
        chk("hold release", 64'(resp_valid), 64'd0);

        // Reset in the middle of a divide
        @(posedge clk);
        #1;
        set_req(0, 3'd4, 32'd100, 32'd3);
        req_valid[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready != 0) break;
        end
        chk("rst div grant", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst div pending", 64'({md_busy, resp_valid}), 64'({1'b1, 2'b00}));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset("midrst");
        rst = 1'b0;
        do_txn("mul3x3", 0, 3'd0, 32'd3, 32'd3, 32'd9, 2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
